// File: rtl/fb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_arb_pkg
// Description : Shared constants and types for the framebuffer port-A arbiter
//               and its clear engine.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_arb_pkg;

  localparam int FB_ADDR_WIDTH = 12;
  localparam int FB_DATA_WIDTH = 8;
  localparam int FB_DEPTH      = 4096;

  // Clear engine sequencing: idle, or filling the framebuffer.
  typedef enum logic [0:0] {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clear_state_e;

  // One port-A transaction as seen by the arbiter.
  typedef struct packed {
    logic                     write;
    logic [FB_ADDR_WIDTH-1:0] address;
    logic [FB_DATA_WIDTH-1:0] data;
  } fb_txn_t;

endpackage
`default_nettype wire

// File: rtl/fb_clear_engine.sv
`default_nettype none
// ============================================================================
// Module      : fb_clear_engine
// Description : Fills every framebuffer address with a latched byte, one
//               write per cycle. Appears to the arbiter as a requester that
//               always wins while it is busy. Only compiled when
//               FB_ARB_CLEAR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef FB_ARB_CLEAR_EN
module fb_clear_engine
  import fb_arb_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [FB_DATA_WIDTH-1:0] value_i,
  output logic                     busy_o,
  output logic                     req_valid_o,
  output fb_txn_t                  req_o
);

  localparam logic [FB_ADDR_WIDTH-1:0] LAST_ADDR = FB_ADDR_WIDTH'(FB_DEPTH - 1);

  clear_state_e             state_q, state_d;
  logic [FB_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [FB_DATA_WIDTH-1:0] fill_q, fill_d;

  // Next-state: a start in IDLE latches the fill byte; CLEAR walks the whole
  // address space and leaves after issuing the last address (counter wraps
  // back to zero on that same step).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    case (state_q)
      CLR_IDLE: begin
        if (start_i) begin
          fill_d  = value_i;
          cnt_d   = '0;
          state_d = CLR_CLEAR;
        end
      end
      CLR_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = CLR_IDLE;
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  // State, counter and fill-byte registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  assign busy_o      = (state_q == CLR_CLEAR);
  assign req_valid_o = busy_o;
  assign req_o       = '{write: 1'b1, address: cnt_q, data: fill_q};

endmodule
`endif
`default_nettype wire

// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_port_arbiter
// Description : Round-robin arbiter sharing framebuffer port A between two
//               requesters, one access per clock, with read data routed back
//               to its owner two cycles after acceptance. The built-in clear
//               engine is compiled in only when FB_ARB_CLEAR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_address,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_address,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  input  logic                  clear_start,
  input  logic [DATA_WIDTH-1:0] clear_value,
  output logic                  clear_busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_write_enable,
  output logic                  ram_clk_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_in
);

  logic    w_clr_valid;
  logic    w_clr_busy;
  fb_txn_t w_clr_txn;

`ifdef FB_ARB_CLEAR_EN
  fb_clear_engine u_clear (
    .clk_i       (clk_in),
    .rst_ni      (reset),
    .start_i     (clear_start),
    .value_i     (clear_value),
    .busy_o      (w_clr_busy),
    .req_valid_o (w_clr_valid),
    .req_o       (w_clr_txn)
  );
`else
  logic w_unused_clear;
  assign w_unused_clear = ^{clear_start, clear_value};
  assign w_clr_valid    = 1'b0;
  assign w_clr_busy     = 1'b0;
  assign w_clr_txn      = '0;
`endif

  // last_q = 1 means requester 1 was served most recently (reset favours 0).
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  ram_we_q, ram_we_d;
  logic                  ram_ce_q, ram_ce_d;
  // Owner tags for reads: stage 1 tracks the RAM access, stage 2 the data.
  logic                  tag1_vld_q, tag1_vld_d, tag1_own_q, tag1_own_d;
  logic                  tag2_vld_q, tag2_own_q;
  logic                  w_gnt0, w_gnt1;

  // Grant decision: clear engine pre-empts both requesters; on a tie the
  // requester not served last wins. Held low while reset is asserted.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset && !w_clr_busy) begin
      w_gnt0 = req0_valid && (!req1_valid || last_q);
      w_gnt1 = req1_valid && (!req0_valid || !last_q);
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  // Stage-1 selection of the access presented to the RAM next cycle.
  always_comb begin
    last_d     = last_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_we_d   = 1'b0;
    ram_ce_d   = 1'b0;
    tag1_vld_d = 1'b0;
    tag1_own_d = 1'b0;
    if (w_clr_valid) begin
      ram_ce_d   = 1'b1;
      ram_we_d   = w_clr_txn.write;
      ram_addr_d = w_clr_txn.address;
      ram_data_d = w_clr_txn.data;
    end else if (w_gnt0) begin
      ram_ce_d   = 1'b1;
      ram_we_d   = req0_write;
      ram_addr_d = req0_address;
      ram_data_d = req0_data;
      tag1_vld_d = !req0_write;
      last_d     = 1'b0;
    end else if (w_gnt1) begin
      ram_ce_d   = 1'b1;
      ram_we_d   = req1_write;
      ram_addr_d = req1_address;
      ram_data_d = req1_data;
      tag1_vld_d = !req1_write;
      tag1_own_d = 1'b1;
      last_d     = 1'b1;
    end
  end

  // Port-A registers, round-robin pointer and read-owner pipeline.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      last_q     <= 1'b1;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_we_q   <= 1'b0;
      ram_ce_q   <= 1'b0;
      tag1_vld_q <= 1'b0;
      tag1_own_q <= 1'b0;
      tag2_vld_q <= 1'b0;
      tag2_own_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_we_q   <= ram_we_d;
      ram_ce_q   <= ram_ce_d;
      tag1_vld_q <= tag1_vld_d;
      tag1_own_q <= tag1_own_d;
      tag2_vld_q <= tag1_vld_q;
      tag2_own_q <= tag1_own_q;
    end
  end

  assign ram_address      = ram_addr_q;
  assign ram_data_out     = ram_data_q;
  assign ram_write_enable = ram_we_q;
  assign ram_clk_enable   = ram_ce_q;

  assign rsp0_valid = tag2_vld_q && !tag2_own_q;
  assign rsp1_valid = tag2_vld_q && tag2_own_q;
  assign rsp0_data  = rsp0_valid ? ram_data_in : '0;
  assign rsp1_data  = rsp1_valid ? ram_data_in : '0;
  assign clear_busy = w_clr_busy;

endmodule
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_port_arbiter
// Description : Self-checking bench for fb_port_arbiter. A transaction-level
//               reference model (request queues, shadow memory, response
//               queue with due cycles) predicts ready, port-A activity,
//               responses and clear_busy every cycle. Clear-engine behaviour
//               is expected only when FB_ARB_CLEAR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_port_arbiter;

`ifdef FB_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif
  localparam int DEPTH = 4096;

  typedef struct {
    bit         wr;
    logic [11:0] a;
    logic [7:0]  d;
  } txn_t;

  typedef struct {
    int         due;
    int         owner;
    logic [7:0] d;
  } rsp_t;

  logic        clk_in;
  logic        reset;
  logic        req0_valid, req0_ready, req0_write;
  logic [11:0] req0_address;
  logic [7:0]  req0_data;
  logic        req1_valid, req1_ready, req1_write;
  logic [11:0] req1_address;
  logic [7:0]  req1_data;
  logic        rsp0_valid, rsp1_valid;
  logic [7:0]  rsp0_data, rsp1_data;
  logic        clear_start, clear_busy;
  logic [7:0]  clear_value;
  logic [11:0] ram_address;
  logic [7:0]  ram_data_out, ram_data_in;
  logic        ram_write_enable, ram_clk_enable;

  fb_port_arbiter dut (
    .clk_in           (clk_in),
    .reset            (reset),
    .req0_valid       (req0_valid),
    .req0_ready       (req0_ready),
    .req0_write       (req0_write),
    .req0_address     (req0_address),
    .req0_data        (req0_data),
    .req1_valid       (req1_valid),
    .req1_ready       (req1_ready),
    .req1_write       (req1_write),
    .req1_address     (req1_address),
    .req1_data        (req1_data),
    .rsp0_valid       (rsp0_valid),
    .rsp0_data        (rsp0_data),
    .rsp1_valid       (rsp1_valid),
    .rsp1_data        (rsp1_data),
    .clear_start      (clear_start),
    .clear_value      (clear_value),
    .clear_busy       (clear_busy),
    .ram_address      (ram_address),
    .ram_data_out     (ram_data_out),
    .ram_write_enable (ram_write_enable),
    .ram_clk_enable   (ram_clk_enable),
    .ram_data_in      (ram_data_in)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Framebuffer RAM port A: registered read, one-cycle latency.
  logic [7:0] mem [DEPTH];
  logic [7:0] ram_q;
  assign ram_data_in = ram_q;
  always @(posedge clk_in) begin
    if (ram_clk_enable) begin
      if (ram_write_enable) mem[ram_address] <= ram_data_out;
      ram_q <= mem[ram_address];
    end
  end

  // ---------------- reference model state ----------------
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         gap = 0;
  txn_t       q0[$];
  txn_t       q1[$];
  bit         pres0, pres1;
  bit         last_m;
  int         clr_left;
  logic [11:0] clr_addr;
  logic [7:0]  clr_val;
  logic [7:0]  shadow [DEPTH];
  rsp_t       rq[$];
  bit         e_ce, e_we;
  logic [11:0] e_addr;
  logic [7:0]  e_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.wr = 1'($urandom_range(1));
    t.a  = 12'($urandom_range(15)) | (($urandom_range(1) == 1) ? 12'hFF0 : 12'h000);
    t.d  = 8'($urandom);
    return t;
  endfunction

  // One clock cycle: present requests, compare DUT against the model at the
  // falling edge, then advance the model by one accepted access.
  task automatic run_cycle();
    int         w;
    bit         busy_m, r0, r1, n_ce, n_we;
    logic [7:0] rd, n_data;
    logic [11:0] n_addr;
    txn_t       t;
    if (!pres0 && q0.size() > 0 && $urandom_range(99) >= gap) pres0 = 1'b1;
    if (!pres1 && q1.size() > 0 && $urandom_range(99) >= gap) pres1 = 1'b1;
    req0_valid = pres0;
    req1_valid = pres1;
    if (pres0) begin
      req0_write = q0[0].wr; req0_address = q0[0].a; req0_data = q0[0].d;
    end else begin
      req0_write = 1'($urandom); req0_address = 12'($urandom); req0_data = 8'($urandom);
    end
    if (pres1) begin
      req1_write = q1[0].wr; req1_address = q1[0].a; req1_data = q1[0].d;
    end else begin
      req1_write = 1'($urandom); req1_address = 12'($urandom); req1_data = 8'($urandom);
    end
    @(negedge clk_in);
    busy_m = (clr_left > 0);
    // Winner: nobody while clearing; a lone requester; on a tie the one not served last.
    w = -1;
    if (!busy_m) begin
      if (pres0 && pres1) w = last_m ? 0 : 1;
      else if (pres0) w = 0;
      else if (pres1) w = 1;
    end
    check("ready0", 32'(req0_ready), 32'(w == 0));
    check("ready1", 32'(req1_ready), 32'(w == 1));
    check("clear_busy", 32'(clear_busy), 32'(busy_m));
    check("ram_ce", 32'(ram_clk_enable), 32'(e_ce));
    if (e_ce) begin
      check("ram_we", 32'(ram_write_enable), 32'(e_we));
      check("ram_addr", 32'(ram_address), 32'(e_addr));
      if (e_we) check("ram_data", 32'(ram_data_out), 32'(e_data));
    end else begin
      check("ram_we_idle", 32'(ram_write_enable), 32'd0);
    end
    r0 = 1'b0; r1 = 1'b0; rd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      rd = rq[0].d;
      if (rq[0].owner == 0) r0 = 1'b1; else r1 = 1'b1;
      rq.delete(0);
    end
    check("rsp0_valid", 32'(rsp0_valid), 32'(r0));
    check("rsp1_valid", 32'(rsp1_valid), 32'(r1));
    if (r0) check("rsp0_data", 32'(rsp0_data), 32'(rd));
    if (r1) check("rsp1_data", 32'(rsp1_data), 32'(rd));
    // Advance the model.
    n_ce = 1'b0; n_we = 1'b0; n_addr = e_addr; n_data = e_data;
    if (busy_m) begin
      n_ce = 1'b1; n_we = 1'b1; n_addr = clr_addr; n_data = clr_val;
      shadow[clr_addr] = clr_val;
      clr_addr = clr_addr + 12'd1;
      clr_left--;
    end else if (w >= 0) begin
      if (w == 0) begin t = q0[0]; q0.delete(0); pres0 = 1'b0; end
      else        begin t = q1[0]; q1.delete(0); pres1 = 1'b0; end
      n_ce = 1'b1; n_we = t.wr; n_addr = t.a; n_data = t.d;
      if (t.wr) shadow[t.a] = t.d;
      else rq.push_back('{cyc + 2, w, shadow[t.a]});
      last_m = (w == 1);
    end
    if (CLR_EN && !busy_m && clear_start) begin
      clr_left = DEPTH;
      clr_addr = '0;
      clr_val  = clear_value;
    end
    e_ce = n_ce; e_we = n_we; e_addr = n_addr; e_data = n_data;
    cyc++;
    @(posedge clk_in);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || rq.size() > 0) && n < max_cycles) begin
      run_cycle();
      n++;
    end
  endtask

  task automatic model_reset();
    last_m   = 1'b1;
    clr_left = 0;
    clr_addr = '0;
    e_ce     = 1'b0;
    e_we     = 1'b0;
    rq.delete();
    // The RAM keeps whatever reached it; an in-flight write may have been cut off.
    for (int i = 0; i < DEPTH; i++) shadow[i] = mem[i];
  endtask

  // Asynchronous reset in the middle of a cycle: outputs must clear at once.
  task automatic async_reset_check();
    #2 reset = 1'b0;
    #1;
    check("arst_ready0", 32'(req0_ready), 32'd0);
    check("arst_ready1", 32'(req1_ready), 32'd0);
    check("arst_ram_ce", 32'(ram_clk_enable), 32'd0);
    check("arst_ram_we", 32'(ram_write_enable), 32'd0);
    check("arst_ram_addr", 32'(ram_address), 32'd0);
    check("arst_ram_data", 32'(ram_data_out), 32'd0);
    check("arst_busy", 32'(clear_busy), 32'd0);
    check("arst_rsp0", 32'(rsp0_valid), 32'd0);
    check("arst_rsp1", 32'(rsp1_valid), 32'd0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req0_valid = 1'b1; req0_write = 1'b0; req0_address = '0; req0_data = '0;
    req1_valid = 1'b1; req1_write = 1'b0; req1_address = '0; req1_data = '0;
    clear_start = 1'b0; clear_value = '0;
    pres0 = 1'b0; pres1 = 1'b0;
    @(posedge clk_in);
    #1;
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp0_data", 32'(rsp0_data), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_rsp1_data", 32'(rsp1_data), 32'd0);
    check("rst_busy", 32'(clear_busy), 32'd0);
    check("rst_ram_addr", 32'(ram_address), 32'd0);
    check("rst_ram_data", 32'(ram_data_out), 32'd0);
    check("rst_ram_we", 32'(ram_write_enable), 32'd0);
    check("rst_ram_ce", 32'(ram_clk_enable), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    model_reset();
    @(negedge clk_in);
    reset = 1'b1;
    @(posedge clk_in);
    #1;

    // Single requester: write then read back.
    q0.push_back('{1'b1, 12'h123, 8'h5A});
    q0.push_back('{1'b0, 12'h123, 8'h00});
    drain(20);

    // Both requesters continuously valid: alternating grants, routed responses.
    q0.push_back('{1'b0, 12'h123, 8'h00});
    q1.push_back('{1'b0, 12'h123, 8'h00});
    q0.push_back('{1'b1, 12'h300, 8'hC3});
    q1.push_back('{1'b1, 12'h301, 8'h3C});
    q0.push_back('{1'b0, 12'h301, 8'h00});
    q1.push_back('{1'b0, 12'h300, 8'h00});
    drain(30);

    // Requester 1 held while requester 0 streams writes.
    for (int i = 0; i < 4; i++) q0.push_back('{1'b1, 12'h400 + 12'(i), 8'h80 + 8'(i)});
    q1.push_back('{1'b1, 12'h7AB, 8'hE1});
    drain(30);

    // Read accepted one cycle before a clear starts; second start mid-fill.
    q0.push_back('{1'b0, 12'h7AB, 8'h00});
    run_cycle();
    clear_value = 8'h00;
    clear_start = 1'b1;
    run_cycle();
    clear_start = 1'b0;
    q0.push_back('{1'b1, 12'h055, 8'h99});
    q1.push_back('{1'b0, 12'h400, 8'h00});
    for (int i = 0; i < 4200; i++) begin
      if (i == 100) begin
        clear_start = 1'b1;
        clear_value = 8'hFF;
      end
      run_cycle();
      clear_start = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b0, 12'($urandom), 8'h00});
      q1.push_back('{1'b0, 12'($urandom), 8'h00});
    end
    drain(40);

    // Asynchronous reset in the middle of a fill.
    clear_value = 8'h3C;
    clear_start = 1'b1;
    run_cycle();
    clear_start = 1'b0;
    q0.push_back('{1'b1, 12'h010, 8'h77});
    q1.push_back('{1'b0, 12'h010, 8'h00});
    for (int i = 0; i < 3000 && clr_left > 0 && clr_addr != 12'h800; i++) run_cycle();
    async_reset_check();
    drain(20);

    // Randomised traffic with idle gaps.
    gap = 30;
    for (int i = 0; i < 600; i++) begin
      if (q0.size() < 3 && $urandom_range(99) < 50) q0.push_back(rand_txn());
      if (q1.size() < 3 && $urandom_range(99) < 50) q1.push_back(rand_txn());
      run_cycle();
    end
    gap = 0;
    drain(50);
    run_cycle();
    run_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
